// File: rtl/watch_timekeeper_if.sv
// Signal bundle between the watch timekeeper core and the mode/button/display side.
interface watch_timekeeper_if;
  logic       seconds_clk;
  logic [2:0] state;
  logic       inc_btn;
  logic [5:0] current_s;
  logic [5:0] current_m;
  logic [5:0] current_h;
  logic       second;
  logic       day_wrap;
  logic [5:0] alarm_h;
  logic [5:0] alarm_m;
  logic       alarm;

  modport master (
    output seconds_clk, state, inc_btn,
    input  current_s, current_m, current_h, second, day_wrap, alarm_h, alarm_m, alarm
  );

  modport slave (
    input  seconds_clk, state, inc_btn,
    output current_s, current_m, current_h, second, day_wrap, alarm_h, alarm_m, alarm
  );
endinterface

// File: rtl/watch_timekeeper.sv
// Time-of-day counter with single-button field setting for the watch chip.
// Define ALARM_EN to build the alarm registers and sticky alarm flag.
module watch_timekeeper #(
  parameter int HOURS       = 24,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  watch_timekeeper_if.slave bus
);

  typedef enum logic [2:0] {
    MODE_RUN        = 3'd0,
    MODE_SET_HOUR   = 3'd1,
    MODE_SET_MIN    = 3'd2,
    MODE_SET_SEC    = 3'd3,
    MODE_ALARM_HOUR = 3'd4,
    MODE_ALARM_MIN  = 3'd5,
    MODE_RUN_6      = 3'd6,
    MODE_RUN_7      = 3'd7
  } mode_t;

  localparam logic [5:0] H_MAX  = 6'(HOURS - 1);
  localparam logic [5:0] MS_MAX = 6'd59;

  mode_t                  mode;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_q;
  logic                   sec_clk_q;
  logic                   tick;
  logic                   inc;
  logic                   run_class;
  logic                   count;
  logic [5:0]             s_q, m_q, h_q;
  logic [5:0]             s_g, m_g, h_g;
  logic [5:0]             s_d, m_d, h_d;
  logic                   second_q, second_d;
  logic                   wrap_q, wrap_d;

  assign mode = mode_t'(bus.state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      btn_q     <= 1'b0;
      sec_clk_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.inc_btn};
      btn_q     <= sync_q[SYNC_STAGES-1];
      sec_clk_q <= bus.seconds_clk;
    end
  end

  assign tick = bus.seconds_clk & ~sec_clk_q;
  assign inc  = sync_q[SYNC_STAGES-1] & ~btn_q;

`ifdef ALARM_EN
  assign run_class = (mode == MODE_RUN) || (mode == MODE_RUN_6) || (mode == MODE_RUN_7);
`else
  assign run_class = !(mode inside {MODE_SET_HOUR, MODE_SET_MIN, MODE_SET_SEC});
`endif

  assign count = tick & run_class;

  // Out-of-range values are treated as 0 so a corrupted field self-heals.
  assign s_g = (s_q > MS_MAX) ? 6'd0 : s_q;
  assign m_g = (m_q > MS_MAX) ? 6'd0 : m_q;
  assign h_g = (h_q > H_MAX)  ? 6'd0 : h_q;

  always_comb begin
    s_d      = s_g;
    m_d      = m_g;
    h_d      = h_g;
    second_d = second_q;
    wrap_d   = 1'b0;
    if (count) begin
      second_d = ~second_q;
      if (s_g == MS_MAX) begin
        s_d = 6'd0;
        if (m_g == MS_MAX) begin
          m_d = 6'd0;
          if (h_g == H_MAX) begin
            h_d    = 6'd0;
            wrap_d = 1'b1;
          end else begin
            h_d = h_g + 6'd1;
          end
        end else begin
          m_d = m_g + 6'd1;
        end
      end else begin
        s_d = s_g + 6'd1;
      end
    end
    // Edits only happen in SET modes, where ticks are never counted.
    if (inc) begin
      case (mode)
        MODE_SET_HOUR: h_d = (h_g == H_MAX)  ? 6'd0 : h_g + 6'd1;
        MODE_SET_MIN:  m_d = (m_g == MS_MAX) ? 6'd0 : m_g + 6'd1;
        MODE_SET_SEC:  s_d = 6'd0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q      <= '0;
      m_q      <= '0;
      h_q      <= '0;
      second_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      s_q      <= s_d;
      m_q      <= m_d;
      h_q      <= h_d;
      second_q <= second_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.current_s = s_q;
  assign bus.current_m = m_q;
  assign bus.current_h = h_q;
  assign bus.second    = second_q;
  assign bus.day_wrap  = wrap_q;

`ifdef ALARM_EN
  logic [5:0] ah_q, am_q, ah_g, am_g, ah_d, am_d;
  logic       alarm_q, alarm_d;

  assign ah_g = (ah_q > H_MAX)  ? 6'd0 : ah_q;
  assign am_g = (am_q > MS_MAX) ? 6'd0 : am_q;

  always_comb begin
    ah_d    = ah_g;
    am_d    = am_g;
    alarm_d = alarm_q;
    if (inc) begin
      case (mode)
        MODE_ALARM_HOUR: ah_d = (ah_g == H_MAX)  ? 6'd0 : ah_g + 6'd1;
        MODE_ALARM_MIN:  am_d = (am_g == MS_MAX) ? 6'd0 : am_g + 6'd1;
        default: ;
      endcase
    end
    if (count && s_d == 6'd0 && m_d == am_g && h_d == ah_g)
      alarm_d = 1'b1;
    // A RUN-mode press acknowledges the alarm and beats a coincident set.
    if (inc && run_class)
      alarm_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ah_q    <= '0;
      am_q    <= '0;
      alarm_q <= 1'b0;
    end else begin
      ah_q    <= ah_d;
      am_q    <= am_d;
      alarm_q <= alarm_d;
    end
  end

  assign bus.alarm_h = ah_q;
  assign bus.alarm_m = am_q;
  assign bus.alarm   = alarm_q;
`else
  assign bus.alarm_h = 6'd0;
  assign bus.alarm_m = 6'd0;
  assign bus.alarm   = 1'b0;
`endif

endmodule

// File: tb/tb_watch_timekeeper.sv
// Randomized bench for watch_timekeeper: a 24-hour and a 12-hour instance run against a
// seconds-of-day reference model.
module tb_watch_timekeeper;

  localparam int SYNC0 = 2;
  localparam int SYNC1 = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sc  = 1'b0;
  logic       btn = 1'b0;
  logic [2:0] st  = 3'd0;

  int tests = 0;
  int fails = 0;

  int tod [2];
  bit blink [2];
  bit wrap_exp [2];
  int ah [2];
  int am [2];
  bit al [2];

  watch_timekeeper_if bus0 ();
  watch_timekeeper_if bus1 ();

  assign bus0.seconds_clk = sc;
  assign bus0.state       = st;
  assign bus0.inc_btn     = btn;
  assign bus1.seconds_clk = sc;
  assign bus1.state       = st;
  assign bus1.inc_btn     = btn;

  watch_timekeeper #(.HOURS(24), .SYNC_STAGES(SYNC0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  watch_timekeeper #(.HOURS(12), .SYNC_STAGES(SYNC1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int hrs(input int i);
    return (i == 0) ? 24 : 12;
  endfunction

  function automatic bit counting(input logic [2:0] m);
`ifdef ALARM_EN
    return (m == 3'd0) || (m == 3'd6) || (m == 3'd7);
`else
    return !(m inside {3'd1, 3'd2, 3'd3});
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      tod[i] = 0; blink[i] = 0; wrap_exp[i] = 0; ah[i] = 0; am[i] = 0; al[i] = 0;
    end
  endfunction

  function automatic void model_tick(input int i);
    wrap_exp[i] = 0;
    if (counting(st)) begin
      tod[i]      = (tod[i] + 1) % (hrs(i) * 3600);
      blink[i]    = !blink[i];
      wrap_exp[i] = (tod[i] == 0);
`ifdef ALARM_EN
      if (tod[i] == ah[i] * 3600 + am[i] * 60) al[i] = 1;
`endif
    end
  endfunction

  function automatic void model_press(input int i);
    int h, m, s;
    h = tod[i] / 3600;
    m = (tod[i] / 60) % 60;
    s = tod[i] % 60;
    case (st)
      3'd1: h = (h + 1) % hrs(i);
      3'd2: m = (m + 1) % 60;
      3'd3: s = 0;
`ifdef ALARM_EN
      3'd4: ah[i] = (ah[i] + 1) % hrs(i);
      3'd5: am[i] = (am[i] + 1) % 60;
`endif
      default: ;
    endcase
`ifdef ALARM_EN
    if (counting(st)) al[i] = 0;
`endif
    tod[i] = h * 3600 + m * 60 + s;
  endfunction

  task automatic check_inst(input string tag, input int i, input logic [5:0] s, input logic [5:0] m,
                            input logic [5:0] h, input logic sec, input logic [5:0] ahv,
                            input logic [5:0] amv, input logic alv);
    checkOutput({tag, (i == 0) ? ".s0" : ".s1"}, s, tod[i] % 60);
    checkOutput({tag, (i == 0) ? ".m0" : ".m1"}, m, (tod[i] / 60) % 60);
    checkOutput({tag, (i == 0) ? ".h0" : ".h1"}, h, tod[i] / 3600);
    checkOutput({tag, (i == 0) ? ".second0" : ".second1"}, sec, blink[i]);
    checkOutput({tag, (i == 0) ? ".alarm_h0" : ".alarm_h1"}, ahv, ah[i]);
    checkOutput({tag, (i == 0) ? ".alarm_m0" : ".alarm_m1"}, amv, am[i]);
    checkOutput({tag, (i == 0) ? ".alarm0" : ".alarm1"}, alv, al[i]);
  endtask

  task automatic check_all(input string tag);
    check_inst(tag, 0, bus0.current_s, bus0.current_m, bus0.current_h, bus0.second,
               bus0.alarm_h, bus0.alarm_m, bus0.alarm);
    check_inst(tag, 1, bus1.current_s, bus1.current_m, bus1.current_h, bus1.second,
               bus1.alarm_h, bus1.alarm_m, bus1.alarm);
  endtask

  task automatic set_mode(input logic [2:0] m);
    @(negedge clk);
    st = m;
  endtask

  // One seconds_clk pulse; the mode may change in the same cycle as the rise.
  task automatic tick_once(input logic [2:0] new_st);
    @(negedge clk);
    st = new_st;
    sc = 1'b1;
    @(posedge clk);
    #1;
    model_tick(0);
    model_tick(1);
    check_all("tick");
    checkOutput("day_wrap0", bus0.day_wrap, wrap_exp[0]);
    checkOutput("day_wrap1", bus1.day_wrap, wrap_exp[1]);
    @(negedge clk);
    sc = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("day_wrap0_end", bus0.day_wrap, 0);
    checkOutput("day_wrap1_end", bus1.day_wrap, 0);
  endtask

  // Hold the button for 'hold' edges; each instance must react exactly on edge SYNC+1.
  task automatic press(input int hold);
    @(negedge clk);
    btn = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk);
      #1;
      if (k == SYNC0 + 1) model_press(0);
      if (k == SYNC1 + 1) model_press(1);
      check_all("press");
    end
    @(negedge clk);
    btn = 1'b0;
    repeat (SYNC1 + 2) @(posedge clk);
    #1;
    check_all("release");
  endtask

  task automatic set_time(input int h, input int m, input int s);
    set_mode(3'd3);
    press(5);
    set_mode(3'd0);
    repeat (s) tick_once(3'd0);
    set_mode(3'd2);
    repeat ((m - (tod[0] / 60) % 60 + 60) % 60) press(5);
    set_mode(3'd1);
    repeat ((h - tod[0] / 3600 + 24) % 24) press(5);
    set_mode(3'd0);
  endtask

  task automatic applyStimulus();
    int op;
    op = $urandom_range(0, 9);
    if (op < 5)
      tick_once((op == 0) ? 3'($urandom_range(0, 7)) : st);
    else if (op < 8)
      press($urandom_range(SYNC1 + 1, SYNC1 + 4));
    else
      set_mode(3'($urandom_range(0, 7)));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    checkOutput("reset_day_wrap", bus0.day_wrap, 0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of a count.
    set_time(5, 6, 7);
    checkOutput("preload_h", bus0.current_h, 5);
    checkOutput("preload_m", bus0.current_m, 6);
    checkOutput("preload_s", bus0.current_s, 7);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick_once(3'd0);
    checkOutput("three_ticks_s", bus0.current_s, 3);
    checkOutput("three_ticks_second", bus0.second, 1);

    // Full-day rollover on both moduli.
    set_time(23, 59, 59);
    checkOutput("prewrap_h12", bus1.current_h, 11);
    tick_once(3'd0);
    checkOutput("wrap_h24", bus0.current_h, 0);
    checkOutput("wrap_h12", bus1.current_h, 0);

    // SET_MIN wraps without carry, holding gives one step, ticks are dropped.
    set_time(3, 59, 20);
    set_mode(3'd2);
    press(5);
    checkOutput("setmin_wrap_m", bus0.current_m, 0);
    checkOutput("setmin_keep_h", bus0.current_h, 3);
    press(100);
    checkOutput("setmin_hold_m", bus0.current_m, 1);
    tick_once(3'd2);
    tick_once(3'd2);
    checkOutput("set_frozen_s", bus0.current_s, 20);

    // SET_SEC clears; returning to RUN on a tick rise counts that tick.
    set_time(4, 15, 42);
    set_mode(3'd3);
    press(5);
    checkOutput("setsec_clear", bus0.current_s, 0);
    tick_once(3'd0);
    checkOutput("resume_s", bus0.current_s, 1);
    press(5);
    checkOutput("run_press_s", bus0.current_s, 1);
    checkOutput("run_press_m", bus0.current_m, 15);

    // Press shortly after reset release.
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    set_mode(3'd1);
    press(5);
    checkOutput("sethour_after_reset", bus0.current_h, 1);
    set_mode(3'd0);

`ifdef ALARM_EN
    set_mode(3'd4);
    repeat ((7 - ah[0] + 24) % 24) press(5);
    set_mode(3'd5);
    repeat ((30 - am[0] + 60) % 60) press(5);
    set_mode(3'd0);
    press(5);
    set_time(7, 29, 59);
    checkOutput("alarm_idle", bus0.alarm, 0);
    tick_once(3'd0);
    checkOutput("alarm_set", bus0.alarm, 1);
    tick_once(3'd0);
    tick_once(3'd0);
    checkOutput("alarm_sticky", bus0.alarm, 1);
    press(5);
    checkOutput("alarm_clear", bus0.alarm, 0);
`endif

    set_mode(3'd0);
    repeat (300) applyStimulus();
    set_mode(3'd0);
    tick_once(3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
